adsr_envelope: RTL and testbench

- ADSR envelope generator that turns a gate (button or sequencer) into a 10-bit amplitude word for the Synth block's amp_in port.
- Sits directly upstream of Synth and replaces the constant 1023 amplitude so that notes swell and decay.
- A prescaled tick, derived from the 48 MHz HFOSC, paces all level updates.
- Stage and end-of-cycle outputs are available to drive the LED16 matrix for visual feedback.

---
 rtl/adsr_envelope.sv | 137 +++++++++++++
 tb/tb_adsr_envelope.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: a synchronized gate drives a five-stage FSM that
// steps a 10-bit amplitude on every prescaler tick.
module adsr_envelope #(
  parameter int CLKSPEED = 48_000_000,
  parameter int TICK_HZ  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       gate,
  input  logic [9:0] attack_rate,
  input  logic [9:0] decay_rate,
  input  logic [9:0] sustain_level,
  input  logic [9:0] release_rate,
  output logic [9:0] amp_out,
  output logic [2:0] stage,
  output logic       tick,
  output logic       eoc
);

  // state     | meaning
  // S_IDLE    | level parked at 0, waiting for gate
  // S_ATTACK  | level climbs by attack_rate per tick up to 1023
  // S_DECAY   | level falls by decay_rate per tick down to sustain_level
  // S_SUSTAIN | level follows sustain_level while gate is held
  // S_RELEASE | level falls by release_rate per tick down to 0
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam int DIV = CLKSPEED / TICK_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          g_meta, g_s, g_prev;
  logic          rise, fall, gate_evt;
  state_t        state, state_nxt;
  logic [9:0]    level, level_nxt;
  logic [10:0]   attack_sum;
  logic [9:0]    decay_gap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      g_meta <= 1'b0;
      g_s    <= 1'b0;
      g_prev <= 1'b0;
    end else begin
      g_meta <= gate;
      g_s    <= g_meta;
      g_prev <= g_s;
    end
  end

  assign rise = g_s & ~g_prev;
  assign fall = ~g_s & g_prev;
  // A fall in IDLE or RELEASE is not an event, so a coincident tick still applies.
  assign gate_evt = rise | (fall & ((state == S_ATTACK) | (state == S_DECAY) |
                                    (state == S_SUSTAIN)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      level <= '0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
    end
  end

  assign attack_sum = {1'b0, level} + {1'b0, attack_rate};
  assign decay_gap  = level - sustain_level;

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    if (rise) begin
      state_nxt = S_ATTACK;
    end else if (gate_evt) begin
      state_nxt = S_RELEASE;
    end else if (tick) begin
      case (state)
        S_ATTACK: begin
          if (attack_sum >= 11'd1023) begin
            level_nxt = 10'd1023;
            state_nxt = S_DECAY;
          end else begin
            level_nxt = attack_sum[9:0];
          end
        end
        S_DECAY: begin
          if ((sustain_level >= level) || (decay_rate >= decay_gap)) begin
            level_nxt = sustain_level;
            state_nxt = S_SUSTAIN;
          end else begin
            level_nxt = level - decay_rate;
          end
        end
        S_SUSTAIN: level_nxt = sustain_level;
        S_RELEASE: begin
          if (release_rate >= level) begin
            level_nxt = '0;
            state_nxt = S_IDLE;
          end else begin
            level_nxt = level - release_rate;
          end
        end
        default: begin
          level_nxt = '0;
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    amp_out = level;
    stage   = state;
    eoc     = rst_n & tick & ~gate_evt & (state == S_RELEASE) & (release_rate >= level);
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed and randomized checks of adsr_envelope against a cycle-level
// arithmetic model of the envelope rules.
module tb_adsr_envelope;
  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       gate = 1'b0;
  logic [9:0] attack_rate = '0, decay_rate = '0, sustain_level = '0, release_rate = '0;
  logic [9:0] amp_out;
  logic [2:0] stage;
  logic       tick, eoc;

  adsr_envelope #(.CLKSPEED(1000), .TICK_HZ(100)) dut (
    .clk(clk), .rst_n(rst_n), .gate(gate),
    .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .amp_out(amp_out), .stage(stage), .tick(tick), .eoc(eoc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int eoc_seen = 0;
  // model: stage number, level, prescaler phase, gate pipeline
  int mst = 0, mlev = 0, mcnt = 0;
  bit ms1 = 0, ms2 = 0, mprev = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int nst, nlev, t;
    bit rise, fall, tk, e_eoc;
    @(negedge clk);
    rise  = ms2 && !mprev;
    fall  = !ms2 && mprev;
    tk    = (mcnt == DIV - 1);
    nst   = mst;
    nlev  = mlev;
    e_eoc = 0;
    if (!rst_n) begin
      nst = 0; nlev = 0;
    end else if (rise) begin
      nst = 1;
    end else if (fall && mst >= 1 && mst <= 3) begin
      nst = 4;
    end else if (tk) begin
      case (mst)
        1: begin
          t = mlev + int'(attack_rate);
          if (t >= 1023) begin nlev = 1023; nst = 2; end else nlev = t;
        end
        2: begin
          t = mlev - int'(decay_rate);
          if (t <= int'(sustain_level)) begin nlev = int'(sustain_level); nst = 3; end
          else nlev = t;
        end
        3: nlev = int'(sustain_level);
        4: begin
          t = mlev - int'(release_rate);
          if (t <= 0) begin nlev = 0; nst = 0; e_eoc = 1; end else nlev = t;
        end
        default: nlev = 0;
      endcase
    end
    check("tick", tick, tk);
    check("eoc", eoc, e_eoc);
    if (eoc === 1'b1) eoc_seen++;
    @(posedge clk);
    if (!rst_n) begin
      mcnt = 0; ms1 = 0; ms2 = 0; mprev = 0;
    end else begin
      mcnt = (mcnt + 1) % DIV;
      mprev = ms2; ms2 = ms1; ms1 = gate;
    end
    mst = nst;
    mlev = nlev;
    #1;
    check("amp_out", amp_out, mlev);
    check("stage", stage, mst);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_stage(input int target, input int bound, input string tag);
    int n = 0;
    while (mst != target && n < bound) begin cycle(); n++; end
    check(tag, stage, target);
  endtask

  task automatic wait_level(input int target, input int bound, input string tag);
    int n = 0;
    while (mlev != target && n < bound) begin cycle(); n++; end
    check(tag, amp_out, target);
  endtask

  initial begin
    // 1: reset and prescaler phase
    repeat (2) @(posedge clk);
    #1;
    cycles(5);
    check("rst_amp", amp_out, 0);
    check("rst_stage", stage, 0);
    check("rst_tick", tick, 0);
    rst_n = 1'b1;
    cycles(9);
    check("first_tick", tick, 1);
    cycles(10);
    check("second_tick", tick, 1);

    // 2: full ADSR cycle
    attack_rate = 10'd256; decay_rate = 10'd100; sustain_level = 10'd600; release_rate = 10'd200;
    gate = 1'b1;
    cycles(3);
    check("gate_to_attack", stage, 1);
    wait_level(1023, 60, "attack_peak");
    check("peak_stage", stage, 2);
    wait_stage(3, 80, "reach_sustain");
    check("sustain_amp", amp_out, 600);
    gate = 1'b0;
    eoc_seen = 0;
    cycles(3);
    check("fall_to_release", stage, 4);
    wait_stage(0, 60, "release_done");
    check("release_eoc_count", eoc_seen, 1);

    // 3: retrigger from release
    sustain_level = 10'd900;
    gate = 1'b1;
    wait_stage(3, 120, "retrig_sustain");
    gate = 1'b0;
    wait_level(700, 40, "release_700");
    gate = 1'b1;
    cycles(3);
    check("retrig_stage", stage, 1);
    check("retrig_hold", amp_out, 700);
    wait_level(956, 20, "retrig_step");

    // 4: gate rise coincident with tick from IDLE
    release_rate = 10'd1023;
    gate = 1'b0;
    wait_stage(0, 40, "idle_again");
    for (int i = 0; i < 20 && mcnt != DIV - 3; i++) cycle();
    gate = 1'b1;
    cycles(3);
    check("coinc_stage", stage, 1);
    check("coinc_amp", amp_out, 0);
    wait_level(256, 20, "coinc_next_tick");

    // 5: saturation, sustain raised mid-decay, frozen release
    attack_rate = 10'd1023; decay_rate = 10'd173; sustain_level = 10'd500;
    wait_level(1023, 20, "attack_sat");
    wait_level(850, 20, "decay_850");
    sustain_level = 10'd900;
    wait_stage(3, 20, "sustain_jump");
    check("sustain_jump_amp", amp_out, 900);
    release_rate = 10'd0;
    gate = 1'b0;
    wait_stage(4, 10, "frozen_release");
    eoc_seen = 0;
    cycles(200);
    check("frozen_amp", amp_out, 900);
    check("frozen_no_eoc", eoc_seen, 0);

    // 6: reset mid-sustain
    release_rate = 10'd200; decay_rate = 10'd1023; sustain_level = 10'd600;
    gate = 1'b1;
    wait_stage(3, 60, "pre_reset_sustain");
    check("pre_reset_amp", amp_out, 600);
    eoc_seen = 0;
    rst_n = 1'b0;
    cycle();
    check("midrst_amp", amp_out, 0);
    check("midrst_stage", stage, 0);
    rst_n = 1'b1;
    cycles(2);
    check("midrst_no_eoc", eoc_seen, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) gate = ~gate;
      if ($urandom_range(0, 99) == 0) begin
        attack_rate   = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
        decay_rate    = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
        sustain_level = 10'($urandom_range(0, 1023));
        release_rate  = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      end
      rst_n = ($urandom_range(0, 499) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
